multiplier_8_sm: RTL and testbench
==================================

Name: multiplier_8_sm

Overview:
- Hardware 8x8 unsigned sequential multiplier. It is the inverse-operation counterpart of the team's 8-bit divider.
- It uses the same operator-facing handshake: Start/Ack buttons and the one-hot INITIAL/COMPUTE/DONE state indicators (Qi/Qc/Qd).
- It is instantiated under a Nexys-4 top wrapper. The wrapper supplies Xin/Yin from the switches and debounced BtnL/BtnR pulses, and shows Product and state on the SSDs and LEDs.
- The algorithm is shift-and-add with early termination once the remaining multiplier bits are zero.

Parameters:
- WIDTH, 8, operand width. Product is 2*WIDTH bits.
- CNT_W, 4, width of the AddCount output. Must satisfy 2^CNT_W > WIDTH.

Ports:
- Clk  input  1  system clock (board_clk in the top).
- Reset_n  input  1  asynchronous, active-low reset.
- Xin  input  WIDTH  multiplicand. Sampled only on the Start cycle in INITIAL.
- Yin  input  WIDTH  multiplier. Sampled only on the Start cycle in INITIAL.
- Start  input  1  begin request. Level-sensitive, acted on only in INITIAL.
- Ack  input  1  acknowledge result. Level-sensitive, acted on only in DONE.
- Product  output  2*WIDTH  registered result.
- AddCount  output  CNT_W  number of shift/add iterations used for the last operation.
- Done  output  1  high in DONE. Identical to Qd.
- Qi, Qc, Qd  output  1 each  one-hot state indicators for INITIAL, COMPUTE, DONE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (Reset_n=0, immediate and asynchronous):
  - state=INITIAL, so Qi=1, Qc=0, Qd=0, Done=0.
  - Product=0, AddCount=0.
  - Internal Mcand (2*WIDTH bits) = 0, Mplier (WIDTH bits) = 0.
- Reset asserted during COMPUTE or DONE aborts the operation and clears everything to the values above. No partial result survives.

- INITIAL:
  - Product and AddCount hold their previous values, so the last result stays displayed.
  - If Start=1:
    - Mcand <= zero-extended Xin.
    - Mplier <= Yin.
    - Product <= 0, AddCount <= 0.
    - Next state is COMPUTE.
  - Start and Ack both high: Start wins. Ack is ignored in INITIAL.

- COMPUTE, one step per clock:
  - If Mplier==0: next state is DONE and all datapath registers hold.
  - Otherwise, in a single cycle:
    - Product <= Product + (Mplier[0] ? Mcand : 0).
    - Mcand <= Mcand << 1.
    - Mplier <= Mplier >> 1 (logical shift).
    - AddCount <= AddCount + 1.
  - Start, Ack, Xin and Yin are all ignored while in COMPUTE.
  - Addition is 2*WIDTH bits wide and cannot overflow, because the maximum product is (2^WIDTH-1)^2.

- Latency:
  - Cycles spent in COMPUTE = k+1, where k = (index of the MSB set in Yin) + 1. If Yin=0 then k=0 and COMPUTE lasts 1 cycle.
  - The maximum is WIDTH+1 cycles.
  - At exit, AddCount = k.

- DONE:
  - Done=Qd=1. Product and AddCount are stable.
  - If Ack=1: next state is INITIAL.
  - Start is ignored in DONE.
  - If Start is still held when returning to INITIAL, a new operation begins on the next cycle. This is intended: the top supplies single-cycle debounced pulses.

- State encoding: one-hot, 3 bits. Qi, Qc and Qd are decoded directly from the state register with no added latency.
- Illegal state (not one-hot): next state is INITIAL.

Decomposition:
- Shared package mult_div_pkg:
  - State localparams QI=3'b001, QC=3'b010, QD=3'b100. The divider reuses the same encoding.
  - Default WIDTH=8.
- No sub-module. The datapath (adder plus two shifters) and the 3-state FSM fit in one module.
- The SSD/LED top wrapper is a separate, existing-style top and is not part of this block.

Test Plan:
- Xin=8'd13, Yin=8'd11, 1-cycle Start -> Qc for exactly 5 cycles, then Qd=1, Product=16'h008F, AddCount=4. Ack pulse -> Qi=1 next cycle and Product holds 16'h008F.
- Xin=8'hFF, Yin=8'hFF -> COMPUTE lasts 9 cycles, Product=16'hFE01, AddCount=8.
- Xin=8'h37, Yin=8'h00 -> COMPUTE lasts 1 cycle, Product=16'h0000, AddCount=0.
- Xin=8'h00, Yin=8'h80 -> 9 COMPUTE cycles, Product=0, AddCount=8. Xin/Yin toggled mid-COMPUTE -> result unaffected.
- Start and Ack high together in INITIAL -> enters COMPUTE. Ack held through COMPUTE -> no effect. Start held in DONE -> stays DONE until Ack.
- Reset_n pulsed low on the 3rd COMPUTE cycle of 13*11 -> outputs go to Qi=1, Product=0, AddCount=0 immediately, without waiting for a clock edge. A subsequent Start with 13*11 gives 16'h008F again.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared definitions for the sequential multiplier and divider: one-hot state
// encoding and default operand widths.
package mult_div_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 4;

  localparam logic [2:0] QI = 3'b001;
  localparam logic [2:0] QC = 3'b010;
  localparam logic [2:0] QD = 3'b100;

  typedef enum logic [2:0] {
    S_INITIAL = QI,
    S_COMPUTE = QC,
    S_DONE    = QD
  } state_e;

endpackage

// File: rtl/multiplier_8_sm.sv
// Unsigned WIDTH x WIDTH shift-and-add multiplier with a Start/Ack operator
// handshake; COMPUTE ends as soon as the remaining multiplier bits are zero.
module multiplier_8_sm
  import mult_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [WIDTH-1:0]   Xin,
  input  logic [WIDTH-1:0]   Yin,
  input  logic               Start,
  input  logic               Ack,
  output logic [2*WIDTH-1:0] Product,
  output logic [CNT_W-1:0]   AddCount,
  output logic               Done,
  output logic               Qi,
  output logic               Qc,
  output logic               Qd
);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_product;
  logic [CNT_W-1:0]     r_add_count;
  logic                 w_load;
  logic                 w_step;
  logic [2*WIDTH-1:0]   w_addend;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_INITIAL;
    else          r_state <= w_state_nxt;
  end

  // NOTE: next-state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_INITIAL: if (Start)            w_state_nxt = S_COMPUTE;
      S_COMPUTE: if (r_mplier == '0)   w_state_nxt = S_DONE;
      S_DONE:    if (Ack)              w_state_nxt = S_INITIAL;
      default:                         w_state_nxt = S_INITIAL;
    endcase
  end

  assign w_load   = (r_state == S_INITIAL) && Start;
  assign w_step   = (r_state == S_COMPUTE) && (r_mplier != '0);
  assign w_addend = r_mplier[0] ? r_mcand : '0;

  // The 2*WIDTH-bit sum cannot wrap: the largest product is (2^WIDTH-1)^2.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_product   <= '0;
      r_add_count <= '0;
    end else if (w_load) begin
      r_mcand     <= {{WIDTH{1'b0}}, Xin};
      r_mplier    <= Yin;
      r_product   <= '0;
      r_add_count <= '0;
    end else if (w_step) begin
      r_mcand     <= r_mcand << 1;
      r_mplier    <= r_mplier >> 1;
      r_product   <= r_product + w_addend;
      r_add_count <= r_add_count + CNT_W'(1);
    end
  end

  assign Product  = r_product;
  assign AddCount = r_add_count;
  assign Qi       = r_state[0];
  assign Qc       = r_state[1];
  assign Qd       = r_state[2];
  assign Done     = r_state[2];

endmodule

// File: tb/tb_multiplier_8_sm.sv
// Directed-vector bench for multiplier_8_sm: latency, results, handshake
// corner cases and asynchronous abort.
module tb_multiplier_8_sm;

  logic        Clk;
  logic        Reset_n;
  logic [7:0]  Xin;
  logic [7:0]  Yin;
  logic        Start;
  logic        Ack;
  logic [15:0] Product;
  logic [3:0]  AddCount;
  logic        Done;
  logic        Qi;
  logic        Qc;
  logic        Qd;

  int n_checks = 0;
  int n_fail   = 0;

  multiplier_8_sm #(.WIDTH(8), .CNT_W(4)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Xin      (Xin),
    .Yin      (Yin),
    .Start    (Start),
    .Ack      (Ack),
    .Product  (Product),
    .AddCount (AddCount),
    .Done     (Done),
    .Qi       (Qi),
    .Qc       (Qc),
    .Qd       (Qd)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Launches one operation from INITIAL and counts negedges with Qc high.
  // Returns with the bench at the first negedge showing Qc low (DONE expected).
  task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                        input bit hold_start, input bit toggle,
                        output int cycles);
    @(negedge Clk);
    Xin   = x;
    Yin   = y;
    Start = 1'b1;
    @(negedge Clk);
    if (!hold_start) Start = 1'b0;
    cycles = 0;
    while (Qc && cycles < 30) begin
      cycles++;
      if (toggle) begin
        Xin = ~Xin;
        Yin = Yin + 8'h35;
      end
      @(negedge Clk);
    end
  endtask

  task automatic do_ack();
    Ack = 1'b1;
    @(negedge Clk);
    Ack = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    Start = 1'b0; Ack = 1'b0; Xin = '0; Yin = '0;
    #12;
    n_checks++;
    if ({Qi, Qc, Qd, Done} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_state: got QiQcQdDone=%b want 1000", {Qi, Qc, Qd, Done});
    end
    n_checks++;
    if (Product !== 16'h0000 || AddCount !== 4'd0) begin
      n_fail++; $display("FAIL reset_data: got P=%h C=%0d want P=0000 C=0", Product, AddCount);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int cyc;
    run_op(8'd13, 8'd11, 1'b0, 1'b0, cyc);
    n_checks++;
    if (cyc !== 5) begin n_fail++; $display("FAIL basic_latency: got %0d want 5", cyc); end
    n_checks++;
    if (Qd !== 1'b1 || Done !== 1'b1) begin
      n_fail++; $display("FAIL basic_done: got Qd=%b Done=%b want 1 1", Qd, Done);
    end
    n_checks++;
    if (Product !== 16'h008F || AddCount !== 4'd4) begin
      n_fail++; $display("FAIL basic_result: got P=%h C=%0d want P=008f C=4", Product, AddCount);
    end
    do_ack();
    n_checks++;
    if (Qi !== 1'b1 || Product !== 16'h008F) begin
      n_fail++; $display("FAIL basic_ack: got Qi=%b P=%h want Qi=1 P=008f", Qi, Product);
    end
    @(negedge Clk);
    n_checks++;
    if (Qi !== 1'b1 || Product !== 16'h008F || AddCount !== 4'd4) begin
      n_fail++; $display("FAIL basic_hold: got Qi=%b P=%h C=%0d want 1 008f 4", Qi, Product, AddCount);
    end
  endtask

  task automatic test_max();
    int cyc;
    run_op(8'hFF, 8'hFF, 1'b0, 1'b0, cyc);
    n_checks++;
    if (cyc !== 9) begin n_fail++; $display("FAIL max_latency: got %0d want 9", cyc); end
    n_checks++;
    if (Qd !== 1'b1 || Product !== 16'hFE01 || AddCount !== 4'd8) begin
      n_fail++; $display("FAIL max_result: got Qd=%b P=%h C=%0d want 1 fe01 8", Qd, Product, AddCount);
    end
    do_ack();
  endtask

  task automatic test_zero_mplier();
    int cyc;
    run_op(8'h37, 8'h00, 1'b0, 1'b0, cyc);
    n_checks++;
    if (cyc !== 1) begin n_fail++; $display("FAIL zero_latency: got %0d want 1", cyc); end
    n_checks++;
    if (Qd !== 1'b1 || Product !== 16'h0000 || AddCount !== 4'd0) begin
      n_fail++; $display("FAIL zero_result: got Qd=%b P=%h C=%0d want 1 0000 0", Qd, Product, AddCount);
    end
    do_ack();
  endtask

  task automatic test_input_toggle();
    int cyc;
    run_op(8'h00, 8'h80, 1'b0, 1'b1, cyc);
    n_checks++;
    if (cyc !== 9) begin n_fail++; $display("FAIL toggle_latency: got %0d want 9", cyc); end
    n_checks++;
    if (Product !== 16'h0000 || AddCount !== 4'd8) begin
      n_fail++; $display("FAIL toggle_result: got P=%h C=%0d want 0000 8", Product, AddCount);
    end
    do_ack();
    run_op(8'd200, 8'd5, 1'b0, 1'b1, cyc);
    n_checks++;
    if (cyc !== 4 || Product !== 16'd1000 || AddCount !== 4'd3) begin
      n_fail++; $display("FAIL toggle_result2: got cyc=%0d P=%h C=%0d want 4 03e8 3", cyc, Product, AddCount);
    end
    do_ack();
  endtask

  task automatic test_start_ack();
    int cyc;
    // Ack high with Start in INITIAL and held through COMPUTE.
    Ack = 1'b1;
    run_op(8'd3, 8'd5, 1'b0, 1'b0, cyc);
    n_checks++;
    if (cyc !== 4 || Qd !== 1'b1 || Product !== 16'd15 || AddCount !== 4'd3) begin
      n_fail++; $display("FAIL start_ack: got cyc=%0d Qd=%b P=%h C=%0d want 4 1 000f 3", cyc, Qd, Product, AddCount);
    end
    @(negedge Clk);
    Ack = 1'b0;
    n_checks++;
    if (Qi !== 1'b1) begin n_fail++; $display("FAIL start_ack_exit: got Qi=%b want 1", Qi); end

    // Start held all the way into DONE.
    run_op(8'd7, 8'd6, 1'b1, 1'b0, cyc);
    repeat (3) @(negedge Clk);
    n_checks++;
    if (Qd !== 1'b1 || Product !== 16'd42 || AddCount !== 4'd3) begin
      n_fail++; $display("FAIL start_in_done: got Qd=%b P=%h C=%0d want 1 002a 3", Qd, Product, AddCount);
    end
    Xin = 8'd2; Yin = 8'd3;
    do_ack();
    n_checks++;
    if (Qi !== 1'b1) begin n_fail++; $display("FAIL start_held_initial: got Qi=%b want 1", Qi); end
    @(negedge Clk);
    Start = 1'b0;
    n_checks++;
    if (Qc !== 1'b1 || Product !== 16'd0) begin
      n_fail++; $display("FAIL start_held_restart: got Qc=%b P=%h want 1 0000", Qc, Product);
    end
    cyc = 0;
    while (!Qd && cyc < 30) begin cyc++; @(negedge Clk); end
    n_checks++;
    if (Qd !== 1'b1 || Product !== 16'd6 || AddCount !== 4'd2) begin
      n_fail++; $display("FAIL start_held_result: got Qd=%b P=%h C=%0d want 1 0006 2", Qd, Product, AddCount);
    end
    do_ack();
  endtask

  task automatic test_async_reset();
    int cyc;
    @(negedge Clk);
    Xin = 8'd13; Yin = 8'd11; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    // Third COMPUTE cycle; Product is already nonzero here.
    #2 Reset_n = 1'b0;
    #1;
    n_checks++;
    if ({Qi, Qc, Qd} !== 3'b100 || Product !== 16'h0000 || AddCount !== 4'd0) begin
      n_fail++; $display("FAIL async_abort: got QiQcQd=%b P=%h C=%0d want 100 0000 0", {Qi, Qc, Qd}, Product, AddCount);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    run_op(8'd13, 8'd11, 1'b0, 1'b0, cyc);
    n_checks++;
    if (cyc !== 5 || Qd !== 1'b1 || Product !== 16'h008F || AddCount !== 4'd4) begin
      n_fail++; $display("FAIL async_rerun: got cyc=%0d Qd=%b P=%h C=%0d want 5 1 008f 4", cyc, Qd, Product, AddCount);
    end
    do_ack();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero_mplier();
    test_input_toggle();
    test_start_ack();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
